// File: rtl/board_datapath_if.sv
// board_datapath_if: signal bundle between the game controller, the board
// memory arbiter and board_datapath.
//
// Handshake: initialize_board / move_piece are single-cycle start pulses that
// the responder honours only while busy=0; initialize_complete / move_complete
// are single-cycle done pulses; mem_we is asserted only in a cycle where
// mem_grant=1, and a write takes effect on that cycle's rising clock edge.
interface board_datapath_if;
   logic       initialize_board;
   logic       move_piece;
   logic [3:0] piece_to_move;
   logic [2:0] origin_x;
   logic [2:0] origin_y;
   logic [2:0] destination_x;
   logic [2:0] destination_y;
   logic       mem_grant;
   logic [3:0] mem_rdata;
   logic [5:0] mem_addr;
   logic [3:0] mem_wdata;
   logic       mem_we;
   logic       initialize_complete;
   logic       move_complete;
   logic [3:0] captured_piece;
   logic       busy;

   // Responder (board_datapath) view
   modport slave (
      input  initialize_board, move_piece, piece_to_move,
      input  origin_x, origin_y, destination_x, destination_y,
      input  mem_grant, mem_rdata,
      output mem_addr, mem_wdata, mem_we,
      output initialize_complete, move_complete, captured_piece, busy
   );

   // Controller / memory view
   modport master (
      output initialize_board, move_piece, piece_to_move,
      output origin_x, origin_y, destination_x, destination_y,
      output mem_grant, mem_rdata,
      input  mem_addr, mem_wdata, mem_we,
      input  initialize_complete, move_complete, captured_piece, busy
   );
endinterface

// File: rtl/board_datapath.sv
// board_datapath: write path into the shared 64-square board memory.
// Loads the starting layout on initialize_board and executes one move
// (read captured piece, write destination, clear origin) on move_piece.
// Memory is driven only in cycles where mem_grant is high.
// Optional macro DATAPATH_PROMOTE_EN: promote pawns reaching the last rank
// to a queen on the destination write.
module board_datapath #(
   parameter int RD_LATENCY   = 1,
   parameter int BOARD_ADDR_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   board_datapath_if.slave  bus,
   output logic [2:0]       fsm_state
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] INIT_WR    = 3'd1;
   localparam logic [2:0] INIT_DONE  = 3'd2;
   localparam logic [2:0] MV_RD      = 3'd3;
   localparam logic [2:0] MV_WR_DST  = 3'd4;
   localparam logic [2:0] MV_CLR_ORG = 3'd5;
   localparam logic [2:0] MV_DONE    = 3'd6;

   localparam logic [1:0] RD_LAT = 2'(RD_LATENCY);

   logic [2:0]              state;
   logic [BOARD_ADDR_W-1:0] init_cnt;
   logic [1:0]              rd_cnt;
   logic [3:0]              piece_q;
   logic [5:0]              org_q;
   logic [5:0]              dst_q;
   logic [3:0]              captured_q;
   logic [3:0]              dst_wdata;
   logic                    same_sq;

   // Starting layout for square a = {y, x}
   function automatic logic [3:0] layout(input logic [5:0] a);
      logic [3:0] back;
      case (a[2:0])
         3'd0:    back = 4'd2;
         3'd1:    back = 4'd3;
         3'd2:    back = 4'd4;
         3'd3:    back = 4'd5;
         3'd4:    back = 4'd6;
         3'd5:    back = 4'd4;
         3'd6:    back = 4'd3;
         default: back = 4'd2;
      endcase
      case (a[5:3])
         3'd0:    return back;
         3'd1:    return 4'd1;
         3'd6:    return 4'd7;
         3'd7:    return back + 4'd6;
         default: return 4'd0;
      endcase
   endfunction

   // A move onto its own square only reads; both writes are suppressed
   assign same_sq = (org_q == dst_q);

   // Piece code written to the destination (optionally promoted)
   always_comb begin
      dst_wdata = piece_q;
`ifdef DATAPATH_PROMOTE_EN
      if (piece_q == 4'd1 && dst_q[5:3] == 3'd7)
         dst_wdata = 4'd5;
      else if (piece_q == 4'd7 && dst_q[5:3] == 3'd0)
         dst_wdata = 4'd11;
`endif
   end

   // Control FSM, init counter, read-latency counter and operand capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         init_cnt   <= '0;
         rd_cnt     <= '0;
         piece_q    <= '0;
         org_q      <= '0;
         dst_q      <= '0;
         captured_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.initialize_board) begin
                  state    <= INIT_WR;
                  init_cnt <= '0;
               end else if (bus.move_piece) begin
                  state   <= MV_RD;
                  rd_cnt  <= '0;
                  piece_q <= bus.piece_to_move;
                  org_q   <= {bus.origin_y, bus.origin_x};
                  dst_q   <= {bus.destination_y, bus.destination_x};
               end
            end
            INIT_WR: begin
               if (bus.mem_grant) begin
                  init_cnt <= init_cnt + 1'b1;
                  if (&init_cnt)
                     state <= INIT_DONE;
               end
            end
            INIT_DONE: state <= IDLE;
            MV_RD: begin
               // Losing the grant mid-read discards the read in flight
               if (!bus.mem_grant)
                  rd_cnt <= '0;
               else if (rd_cnt == RD_LAT) begin
                  captured_q <= bus.mem_rdata;
                  state      <= MV_WR_DST;
               end else
                  rd_cnt <= rd_cnt + 1'b1;
            end
            MV_WR_DST: begin
               if (bus.mem_grant)
                  state <= MV_CLR_ORG;
            end
            MV_CLR_ORG: begin
               if (bus.mem_grant)
                  state <= MV_DONE;
            end
            MV_DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Memory bus drive; write enable always qualified by the grant
   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_we    = 1'b0;
      case (state)
         INIT_WR: begin
            bus.mem_addr  = 6'(init_cnt);
            bus.mem_wdata = layout(6'(init_cnt));
            bus.mem_we    = bus.mem_grant;
         end
         MV_RD: begin
            bus.mem_addr = dst_q;
         end
         MV_WR_DST: begin
            bus.mem_addr  = dst_q;
            bus.mem_wdata = dst_wdata;
            bus.mem_we    = bus.mem_grant & ~same_sq;
         end
         MV_CLR_ORG: begin
            bus.mem_addr = org_q;
            bus.mem_we   = bus.mem_grant & ~same_sq;
         end
         default: begin
         end
      endcase
   end

   assign bus.initialize_complete = (state == INIT_DONE);
   assign bus.move_complete       = (state == MV_DONE);
   assign bus.busy                = (state != IDLE);
   assign bus.captured_piece      = captured_q;
   assign fsm_state               = state;

endmodule

// File: tb/tb_board_datapath.sv
// tb_board_datapath: scoreboard bench for board_datapath. A reference board
// array predicts memory writes, captured pieces and done-pulse cycles; a
// negedge monitor pops and compares whenever the DUT writes or completes.
module tb_board_datapath;
   localparam int RD_LAT = 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [2:0] fsm_state;
   int cyc = 0;
   int errors = 0;
   int checks = 0;
   bit rand_grant = 1'b0;

   board_datapath_if bus();

   board_datapath #(.RD_LATENCY(RD_LAT), .BOARD_ADDR_W(6)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .fsm_state(fsm_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Board memory with RD_LAT-cycle read pipeline
   logic [3:0] mem [64];
   logic [3:0] rd_pipe [2];
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      rd_pipe[0] <= mem[bus.mem_addr];
      rd_pipe[1] <= rd_pipe[0];
   end
   assign bus.mem_rdata = rd_pipe[RD_LAT-1];

   // Reference model and scoreboard queues
   logic [3:0] board [64];
   logic [3:0] back_rank [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd4, 4'd3, 4'd2};
   logic [9:0] exp_q[$];          // {addr, data} of each expected write
   int         exp_init_q[$];     // expected init done cycle, -1 = any
   int         exp_mv_cyc_q[$];   // expected move done cycle, -1 = any
   logic [3:0] exp_mv_cap_q[$];   // expected captured piece

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] ref_layout(input int sq);
      int y = sq / 8;
      int x = sq % 8;
      if (y == 0) return back_rank[x];
      if (y == 1) return 4'd1;
      if (y == 6) return 4'd7;
      if (y == 7) return back_rank[x] + 4'd6;
      return 4'd0;
   endfunction

   function automatic logic [3:0] ref_promote(input logic [3:0] p, input int dy);
      logic [3:0] r = p;
`ifdef DATAPATH_PROMOTE_EN
      if (p == 4'd1 && dy == 7) r = 4'd5;
      if (p == 4'd7 && dy == 0) r = 4'd11;
`endif
      return r;
   endfunction

   task automatic push_init(input int exp_cycle);
      for (int a = 0; a < 64; a++) begin
         board[a] = ref_layout(a);
         exp_q.push_back({6'(a), ref_layout(a)});
      end
      exp_init_q.push_back(exp_cycle);
   endtask

   task automatic push_move(input logic [3:0] piece, input int ox, input int oy,
                            input int dx, input int dy, input int exp_cycle);
      int o = oy * 8 + ox;
      int d = dy * 8 + dx;
      logic [3:0] wp;
      exp_mv_cap_q.push_back(board[d]);
      exp_mv_cyc_q.push_back(exp_cycle);
      if (o != d) begin
         wp = ref_promote(piece, dy);
         exp_q.push_back({6'(d), wp});
         exp_q.push_back({6'(o), 4'd0});
         board[d] = wp;
         board[o] = 4'd0;
      end
   endtask

   // Monitor: compare every write and done pulse against the queues
   always @(negedge clk) begin
      logic [9:0] w;
      int e;
      if (!reset) begin
         if (bus.mem_we) begin
            check("we_only_with_grant", int'(bus.mem_grant), 1);
            check("write_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               w = exp_q.pop_front();
               check("wr_addr", int'(bus.mem_addr), int'(w[9:4]));
               check("wr_data", int'(bus.mem_wdata), int'(w[3:0]));
            end
         end
         if (bus.initialize_complete) begin
            check("init_done_expected", int'(exp_init_q.size() > 0), 1);
            if (exp_init_q.size() > 0) begin
               e = exp_init_q.pop_front();
               if (e >= 0) check("init_done_cycle", cyc, e);
            end
         end
         if (bus.move_complete) begin
            check("move_done_expected", int'(exp_mv_cyc_q.size() > 0), 1);
            if (exp_mv_cyc_q.size() > 0) begin
               e = exp_mv_cyc_q.pop_front();
               if (e >= 0) check("move_done_cycle", cyc, e);
               check("captured_piece", int'(bus.captured_piece), int'(exp_mv_cap_q.pop_front()));
            end
         end
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_move_ops(input logic [3:0] piece, input int ox, input int oy,
                               input int dx, input int dy);
      bus.piece_to_move = piece;
      bus.origin_x      = 3'(ox);
      bus.origin_y      = 3'(oy);
      bus.destination_x = 3'(dx);
      bus.destination_y = 3'(dy);
   endtask

   task automatic scramble_ops();
      set_move_ops(4'($urandom_range(0, 15)), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 7));
   endtask

   task automatic start_init(input int extra);
      bus.initialize_board = 1'b1;
      push_init(cyc + 65 + extra);
      tick();
      bus.initialize_board = 1'b0;
      check("busy_after_init_start", int'(bus.busy), 1);
   endtask

   task automatic start_move(input logic [3:0] piece, input int ox, input int oy,
                             input int dx, input int dy, input bit timed);
      set_move_ops(piece, ox, oy, dx, dy);
      bus.move_piece = 1'b1;
      push_move(piece, ox, oy, dx, dy, timed ? cyc + RD_LAT + 4 : -1);
      tick();
      bus.move_piece = 1'b0;
      scramble_ops();
      check("busy_after_move_start", int'(bus.busy), 1);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((exp_init_q.size() + exp_mv_cyc_q.size()) > 0 && n < 400) begin
         if (rand_grant) bus.mem_grant = ($urandom_range(0, 3) != 0);
         tick();
         n++;
      end
      bus.mem_grant = 1'b1;
      check({name, "_no_timeout"}, int'(n < 400), 1);
      check({name, "_writes_drained"}, exp_q.size(), 0);
      check({name, "_idle_after"}, int'(bus.busy), 0);
      if (n >= 400) begin
         exp_q.delete();
         exp_init_q.delete();
         exp_mv_cyc_q.delete();
         exp_mv_cap_q.delete();
      end
   endtask

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      bus.initialize_board = 1'b0;
      bus.move_piece       = 1'b0;
      bus.mem_grant        = 1'b1;
      set_move_ops(4'd0, 0, 0, 0, 0);
      reset = 1'b1;
      repeat (3) tick();
      check("rst_mem_addr", int'(bus.mem_addr), 0);
      check("rst_mem_wdata", int'(bus.mem_wdata), 0);
      check("rst_mem_we", int'(bus.mem_we), 0);
      check("rst_init_complete", int'(bus.initialize_complete), 0);
      check("rst_move_complete", int'(bus.move_complete), 0);
      check("rst_captured", int'(bus.captured_piece), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_state", int'(fsm_state), 0);
      reset = 1'b0;
      tick();

      // Full initialisation with continuous grant
      start_init(0);
      wait_done("init");

      // Directed moves
      start_move(4'd1, 4, 1, 4, 3, 1'b1);
      wait_done("move_pawn");
      start_move(4'd5, 3, 0, 3, 7, 1'b1);
      wait_done("move_capture");
      start_move(4'd1, 0, 6, 0, 7, 1'b1);
      wait_done("move_last_rank");
      start_move(4'd9, 2, 2, 2, 2, 1'b1);
      wait_done("move_same_square");

      // Reset in the middle of a move: no writes, no done pulse
      set_move_ops(4'd3, 1, 0, 2, 2);
      bus.move_piece = 1'b1;
      tick();
      bus.move_piece = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midreset_busy", int'(bus.busy), 0);
      check("midreset_state", int'(fsm_state), 0);
      repeat (10) tick();
      check("midreset_still_idle", int'(bus.busy), 0);

      // Init with a 5-cycle grant gap at counter 10
      bus.initialize_board = 1'b1;
      push_init(cyc + 70);
      tick();
      bus.initialize_board = 1'b0;
      repeat (10) tick();
      bus.mem_grant = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("gap_we_low", int'(bus.mem_we), 0);
         check("gap_addr_held", int'(bus.mem_addr), 10);
         tick();
      end
      bus.mem_grant = 1'b1;
      wait_done("init_grant_gap");

      // Simultaneous start pulses, then a move pulse while busy
      set_move_ops(4'd2, 0, 0, 0, 3);
      bus.initialize_board = 1'b1;
      bus.move_piece       = 1'b1;
      push_init(cyc + 65);
      tick();
      bus.initialize_board = 1'b0;
      bus.move_piece       = 1'b0;
      repeat (3) tick();
      bus.move_piece = 1'b1;
      tick();
      bus.move_piece = 1'b0;
      wait_done("init_wins");
      repeat (4) tick();

      // Randomised moves, alternating steady and random grant
      for (int i = 0; i < 30; i++) begin
         int ox = $urandom_range(0, 7);
         int oy = $urandom_range(0, 7);
         int dx = $urandom_range(0, 7);
         int dy = $urandom_range(0, 7);
         if (i % 7 == 0) begin
            dx = ox;
            dy = oy;
         end
         rand_grant = (i % 2 == 1);
         start_move(4'($urandom_range(1, 12)), ox, oy, dx, dy, !rand_grant);
         wait_done("rand_move");
      end
      rand_grant = 1'b0;

      // Final board contents against the model
      for (int a = 0; a < 64; a++) check("final_board", int'(mem[a]), int'(board[a]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
